// File: rtl/upsampler_pkg.sv
// rtl/upsampler_pkg.sv - shared state encoding and counter-width helpers for upsampler_nn
package upsampler_pkg;

  typedef enum logic {
    LIVE   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  // Bits needed for a counter spanning 0..max_val
  function automatic int cnt_w(input int max_val);
    return clog2_min1(max_val + 1);
  endfunction

endpackage

// File: rtl/upsampler_line_buf.sv
// rtl/upsampler_line_buf.sv - one-row pixel store, single write port, asynchronous read
module upsampler_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 800,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/upsampler_nn.sv
// rtl/upsampler_nn.sv - nearest-neighbour upsampler: SCALE x SCALE pixel replication with eol/eof markers
module upsampler_nn
  import upsampler_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IN_WIDTH  = 800,
  parameter int IN_HEIGHT = 600,
  parameter int SCALE     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              out_eol,
  output logic              out_eof
);

  localparam int COL_W = cnt_w(IN_WIDTH - 1);
  localparam int REP_W = cnt_w(SCALE - 1);
  localparam int ROW_W = cnt_w(IN_HEIGHT - 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(SCALE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [REP_W-1:0]  rx, rx_nxt;
  logic [REP_W-1:0]  ry, ry_nxt;
  logic [ROW_W-1:0]  row, row_nxt;

  logic              adv;
  logic              load;
  logic              accept;
  logic              at_eol;
  logic              at_ry_last;
  logic              at_eof;
  logic [DATA_W-1:0] dout_nxt;
  logic [DATA_W-1:0] lb_rdata;

  // The output register may take a new pixel whenever it is empty or being drained
  assign adv = !out_valid || out_ready;

  upsampler_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IN_WIDTH),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (col),
    .wdata (din),
    .raddr (col),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LIVE;
    else     state <= state_nxt;
  end

  always_comb begin
    in_ready   = 1'b0;
    load       = 1'b0;
    accept     = 1'b0;
    dout_nxt   = dout;
    state_nxt  = state;
    col_nxt    = col;
    rx_nxt     = rx;
    ry_nxt     = ry;
    row_nxt    = row;
    at_eol     = (col == COL_LAST) && (rx == REP_LAST);
    at_ry_last = (ry == REP_LAST);
    at_eof     = at_eol && at_ry_last && (row == ROW_LAST);

    case (state)
      LIVE: begin
        if (rx == '0) begin
          in_ready = adv;
          accept   = adv && in_valid;
          load     = accept;
          dout_nxt = din;
        end else begin
          load     = adv;
        end
      end
      REPLAY: begin
        load     = adv;
        dout_nxt = lb_rdata;
      end
      default: ;
    endcase

    if (load) begin
      if (rx == REP_LAST) begin
        rx_nxt  = '0;
        col_nxt = at_eol ? '0 : col + 1'b1;
      end else begin
        rx_nxt  = rx + 1'b1;
      end
      // Row bookkeeping: replay the stored line SCALE-1 more times before taking new input
      if (at_eol) begin
        if (at_ry_last) begin
          ry_nxt    = '0;
          state_nxt = LIVE;
          row_nxt   = (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          ry_nxt    = ry + 1'b1;
          state_nxt = REPLAY;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      rx  <= '0;
      ry  <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      rx  <= rx_nxt;
      ry  <= ry_nxt;
      row <= row_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (adv) begin
      out_valid <= load;
      if (load) begin
        dout    <= dout_nxt;
        out_eol <= at_eol;
        out_eof <= at_eof;
      end
    end
  end

endmodule
